// File: rtl/mips_sopc.sv
// mips_sopc: 5-stage MIPS32 integer core (IF/ID/EX/MEM/WB) with a word-addressed instruction ROM.
// Build option SOPC_FORWARD_EN: EX/MEM operand forwarding into ID; when undefined, ID interlocks instead.

module sopc_rom #(
    parameter int ROM_DEPTH = 1024
) (
    input  logic        reset,
    input  logic [31:0] addr,
    output logic [31:0] data
);
    localparam int AW = $clog2(ROM_DEPTH);

    logic [31:0] storage [0:ROM_DEPTH-1];
    logic        unused_addr_s;

    assign unused_addr_s = ^{addr[31:AW+2], addr[1:0]};

    // Combinational word read, forced to zero while the system is in reset
    always_comb begin
        if (reset) begin
            data = 32'd0;
        end else begin
            data = storage[addr[AW+1:2]];
        end
    end
endmodule

module sopc_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] storage [0:31];

    // Architectural write at the WB edge; r0 is never written
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                storage[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            storage[waddr] <= wdata;
        end
    end

    // Read ports; a write landing this cycle is bypassed into the read
    always_comb begin
        if (raddr_a == 5'd0) begin
            rdata_a = 32'd0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = storage[raddr_a];
        end
        if (raddr_b == 5'd0) begin
            rdata_b = 32'd0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = storage[raddr_b];
        end
    end
endmodule

module sopc_core #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);
    typedef enum logic [3:0] {
        OP_NOP, OP_OR, OP_AND, OP_XOR, OP_NOR, OP_ADD, OP_SUB,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MUL
    } alu_op_e;

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    alu_op_e     ex_op_q, ex_op_d;
    logic [31:0] ex_opa_q, ex_opa_d, ex_opb_q, ex_opb_d;
    logic        ex_wreg_q, ex_wreg_d;
    logic [4:0]  ex_waddr_q, ex_waddr_d;
    logic        mem_wreg_q, mem_wreg_d;
    logic [4:0]  mem_waddr_q, mem_waddr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, sa_s;
    logic [15:0] imm16_s;
    alu_op_e     id_op_s;
    logic        id_wreg_s, use_rs_s, use_rt_s, use_sa_s;
    logic [4:0]  id_waddr_s;
    logic [31:0] imm_s, rf_a_s, rf_b_s, rs_val_s, rt_val_s, id_opa_s, id_opb_s;
    logic [31:0] ex_result_s;
    logic        mul_busy_s, id_hazard_s;
    logic [5:0]  stall_s;

    function automatic logic dep_hit(input logic used, input logic [4:0] src,
                                     input logic wreg, input logic [4:0] waddr);
        return used && (src != 5'd0) && wreg && (waddr == src);
    endfunction

    assign rom_addr = pc_q;
    assign opcode_s = if_instr_q[31:26];
    assign rs_s     = if_instr_q[25:21];
    assign rt_s     = if_instr_q[20:16];
    assign rd_s     = if_instr_q[15:11];
    assign sa_s     = if_instr_q[10:6];
    assign funct_s  = if_instr_q[5:0];
    assign imm16_s  = if_instr_q[15:0];

    sopc_regfile register (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_wreg_q),
        .waddr   (wb_waddr_q),
        .wdata   (wb_wdata_q),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rf_a_s),
        .rdata_b (rf_b_s)
    );

    // Instruction decode; unrecognised encodings fall through as NOP
    always_comb begin
        id_op_s    = OP_NOP;
        id_wreg_s  = 1'b0;
        id_waddr_s = 5'd0;
        use_rs_s   = 1'b0;
        use_rt_s   = 1'b0;
        use_sa_s   = 1'b0;
        imm_s      = 32'd0;
        case (opcode_s)
            6'h0D: begin id_op_s = OP_OR;  id_wreg_s = 1'b1; id_waddr_s = rt_s; use_rs_s = 1'b1; imm_s = {16'd0, imm16_s}; end
            6'h0C: begin id_op_s = OP_AND; id_wreg_s = 1'b1; id_waddr_s = rt_s; use_rs_s = 1'b1; imm_s = {16'd0, imm16_s}; end
            6'h0E: begin id_op_s = OP_XOR; id_wreg_s = 1'b1; id_waddr_s = rt_s; use_rs_s = 1'b1; imm_s = {16'd0, imm16_s}; end
            6'h0F: begin id_op_s = OP_OR;  id_wreg_s = 1'b1; id_waddr_s = rt_s; imm_s = {imm16_s, 16'd0}; end
            6'h09: begin id_op_s = OP_ADD; id_wreg_s = 1'b1; id_waddr_s = rt_s; use_rs_s = 1'b1; imm_s = {{16{imm16_s[15]}}, imm16_s}; end
            6'h00: begin
                id_wreg_s  = 1'b1;
                id_waddr_s = rd_s;
                use_rs_s   = 1'b1;
                use_rt_s   = 1'b1;
                case (funct_s)
                    6'h21:   id_op_s = OP_ADD;
                    6'h23:   id_op_s = OP_SUB;
                    6'h24:   id_op_s = OP_AND;
                    6'h25:   id_op_s = OP_OR;
                    6'h26:   id_op_s = OP_XOR;
                    6'h27:   id_op_s = OP_NOR;
                    6'h2A:   id_op_s = OP_SLT;
                    6'h2B:   id_op_s = OP_SLTU;
                    6'h00:   begin id_op_s = OP_SLL; use_rs_s = 1'b0; use_sa_s = 1'b1; end
                    6'h02:   begin id_op_s = OP_SRL; use_rs_s = 1'b0; use_sa_s = 1'b1; end
                    6'h03:   begin id_op_s = OP_SRA; use_rs_s = 1'b0; use_sa_s = 1'b1; end
                    default: begin id_op_s = OP_NOP; id_wreg_s = 1'b0; use_rs_s = 1'b0; use_rt_s = 1'b0; end
                endcase
            end
            6'h1C: begin
                if (funct_s == 6'h02) begin
                    id_op_s    = OP_MUL;
                    id_wreg_s  = 1'b1;
                    id_waddr_s = rd_s;
                    use_rs_s   = 1'b1;
                    use_rt_s   = 1'b1;
                end else begin
                    id_op_s    = OP_NOP;
                end
            end
            default: id_op_s = OP_NOP;
        endcase
    end

    // Operand selection: youngest producer wins (EX, then MEM, then regfile/WB bypass)
    always_comb begin
        rs_val_s = rf_a_s;
        rt_val_s = rf_b_s;
`ifdef SOPC_FORWARD_EN
        if (dep_hit(1'b1, rs_s, ex_wreg_q, ex_waddr_q)) begin
            rs_val_s = ex_result_s;
        end else if (dep_hit(1'b1, rs_s, mem_wreg_q, mem_waddr_q)) begin
            rs_val_s = mem_wdata_q;
        end else begin
            rs_val_s = rf_a_s;
        end
        if (dep_hit(1'b1, rt_s, ex_wreg_q, ex_waddr_q)) begin
            rt_val_s = ex_result_s;
        end else if (dep_hit(1'b1, rt_s, mem_wreg_q, mem_waddr_q)) begin
            rt_val_s = mem_wdata_q;
        end else begin
            rt_val_s = rf_b_s;
        end
        id_hazard_s = 1'b0;
`else
        id_hazard_s = dep_hit(use_rs_s, rs_s, ex_wreg_q, ex_waddr_q)
                    | dep_hit(use_rs_s, rs_s, mem_wreg_q, mem_waddr_q)
                    | dep_hit(use_rt_s, rt_s, ex_wreg_q, ex_waddr_q)
                    | dep_hit(use_rt_s, rt_s, mem_wreg_q, mem_waddr_q);
`endif
        if (use_rs_s) begin
            id_opa_s = rs_val_s;
        end else if (use_sa_s) begin
            id_opa_s = {27'd0, sa_s};
        end else begin
            id_opa_s = 32'd0;
        end
        if (use_rt_s) begin
            id_opb_s = rt_val_s;
        end else begin
            id_opb_s = imm_s;
        end
    end

    // Execute stage ALU; all arithmetic wraps at 32 bits
    always_comb begin
        case (ex_op_q)
            OP_OR:   ex_result_s = ex_opa_q | ex_opb_q;
            OP_AND:  ex_result_s = ex_opa_q & ex_opb_q;
            OP_XOR:  ex_result_s = ex_opa_q ^ ex_opb_q;
            OP_NOR:  ex_result_s = ~(ex_opa_q | ex_opb_q);
            OP_ADD:  ex_result_s = ex_opa_q + ex_opb_q;
            OP_SUB:  ex_result_s = ex_opa_q - ex_opb_q;
            OP_SLT:  ex_result_s = {31'd0, ($signed(ex_opa_q) < $signed(ex_opb_q))};
            OP_SLTU: ex_result_s = {31'd0, (ex_opa_q < ex_opb_q)};
            OP_SLL:  ex_result_s = ex_opb_q << ex_opa_q[4:0];
            OP_SRL:  ex_result_s = ex_opb_q >> ex_opa_q[4:0];
            OP_SRA:  ex_result_s = $signed(ex_opb_q) >>> ex_opa_q[4:0];
            OP_MUL:  ex_result_s = ex_opa_q * ex_opb_q;
            default: ex_result_s = 32'd0;
        endcase
    end

    // Stall control and next-state for every pipeline register
    always_comb begin
        mul_busy_s = (ex_op_q == OP_MUL) && (mul_cnt_q != MUL_LAST);
        if (mul_busy_s) begin
            stall_s   = 6'b001111;
            mul_cnt_d = mul_cnt_q + 1'b1;
        end else if (id_hazard_s) begin
            stall_s   = 6'b000111;
            mul_cnt_d = '0;
        end else begin
            stall_s   = 6'b000000;
            mul_cnt_d = '0;
        end

        if (stall_s[0]) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + 32'd4;
        end

        if (stall_s[1] && !stall_s[2]) begin
            if_instr_d = 32'd0;
        end else if (stall_s[1]) begin
            if_instr_d = if_instr_q;
        end else begin
            if_instr_d = rom_data;
        end

        if (stall_s[2] && !stall_s[3]) begin
            ex_op_d = OP_NOP; ex_opa_d = 32'd0; ex_opb_d = 32'd0; ex_wreg_d = 1'b0; ex_waddr_d = 5'd0;
        end else if (stall_s[2]) begin
            ex_op_d = ex_op_q; ex_opa_d = ex_opa_q; ex_opb_d = ex_opb_q; ex_wreg_d = ex_wreg_q; ex_waddr_d = ex_waddr_q;
        end else begin
            ex_op_d = id_op_s; ex_opa_d = id_opa_s; ex_opb_d = id_opb_s; ex_wreg_d = id_wreg_s; ex_waddr_d = id_waddr_s;
        end

        if (stall_s[3] && !stall_s[4]) begin
            mem_wreg_d = 1'b0; mem_waddr_d = 5'd0; mem_wdata_d = 32'd0;
        end else if (stall_s[3]) begin
            mem_wreg_d = mem_wreg_q; mem_waddr_d = mem_waddr_q; mem_wdata_d = mem_wdata_q;
        end else begin
            mem_wreg_d = ex_wreg_q; mem_waddr_d = ex_waddr_q; mem_wdata_d = ex_result_s;
        end

        if (stall_s[4] && !stall_s[5]) begin
            wb_wreg_d = 1'b0; wb_waddr_d = 5'd0; wb_wdata_d = 32'd0;
        end else if (stall_s[4]) begin
            wb_wreg_d = wb_wreg_q; wb_waddr_d = wb_waddr_q; wb_wdata_d = wb_wdata_q;
        end else begin
            wb_wreg_d = mem_wreg_q; wb_waddr_d = mem_waddr_q; wb_wdata_d = mem_wdata_q;
        end
    end

    // Pipeline state registers; reset flushes every stage to NOP
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= 32'd0;
            if_instr_q  <= 32'd0;
            ex_op_q     <= OP_NOP;
            ex_opa_q    <= 32'd0;
            ex_opb_q    <= 32'd0;
            ex_wreg_q   <= 1'b0;
            ex_waddr_q  <= 5'd0;
            mem_wreg_q  <= 1'b0;
            mem_waddr_q <= 5'd0;
            mem_wdata_q <= 32'd0;
            wb_wreg_q   <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= 32'd0;
            mul_cnt_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            if_instr_q  <= if_instr_d;
            ex_op_q     <= ex_op_d;
            ex_opa_q    <= ex_opa_d;
            ex_opb_q    <= ex_opb_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_waddr_q  <= ex_waddr_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            mul_cnt_q   <= mul_cnt_d;
        end
    end
endmodule

module mips_sopc #(
    parameter int ROM_DEPTH  = 1024,
    parameter int MUL_CYCLES = 3
) (
    input logic clock,
    input logic reset
);
    logic [31:0] rom_addr_s;
    logic [31:0] rom_data_s;

    sopc_core #(.MUL_CYCLES(MUL_CYCLES)) cpu (
        .clock    (clock),
        .reset    (reset),
        .rom_addr (rom_addr_s),
        .rom_data (rom_data_s)
    );

    sopc_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
        .reset (reset),
        .addr  (rom_addr_s),
        .data  (rom_data_s)
    );
endmodule

// File: tb/tb_mips_sopc.sv
// Bench for mips_sopc: ROM programs are written through the hierarchy, register
// results are checked against a scoreboard of (edge, register, value) expectations.
module tb_mips_sopc;
    localparam int MC = 3;
    localparam logic [5:0] ORI = 6'h0D, ANDI = 6'h0C, XORI = 6'h0E, LUI = 6'h0F, ADDIU = 6'h09;

`ifdef SOPC_FORWARD_EN
    localparam int W1 = 6, W2 = 7, W3 = 8;
    localparam int R1 = 7 + (MC - 1), R4 = 8 + (MC - 1);
    localparam int MID = 5;
`else
    localparam int W1 = 8, W2 = 9, W3 = 10;
    localparam int R1 = 9 + (MC - 1), R4 = 10 + (MC - 1);
    localparam int MID = 7;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    mips_sopc #(.ROM_DEPTH(1024), .MUL_CYCLES(MC)) dut (.clock(clock), .reset(reset));

    always #5 clock = ~clock;

    typedef struct {
        int          at;
        int          r;
        logic [31:0] val;
        string       tag;
    } exp_t;

    typedef struct {
        string       tag;
        logic [31:0] i0, i1, i2, i3;
        int          r;
        logic [31:0] val;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] rr(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] sh(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] sa);
        return {6'h00, 5'd0, rt, rd, sa, fn};
    endfunction
    function automatic logic [31:0] mul(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h1C, rs, rt, rd, 5'd0, 6'h02};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic expect_at(input int at, input int r, input logic [31:0] val, input string tag);
        sb_q.push_back('{at: at, r: r, val: val, tag: tag});
    endtask

    task automatic add_vec(input string tag, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] i2, input logic [31:0] i3, input int r, input logic [31:0] val);
        vecs.push_back('{tag: tag, i0: i0, i1: i1, i2: i2, i3: i3, r: r, val: val});
    endtask

    // One clock; sample #1 after the edge and retire every expectation due now
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        edge_n++;
        while (sb_q.size() > 0 && sb_q[0].at <= edge_n) begin
            e = sb_q.pop_front();
            if (e.at < edge_n) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: missed at edge %0d expected %08h", e.tag, e.at, e.val);
            end else begin
                check(e.tag, dut.cpu.register.storage[e.r], e.val);
            end
        end
    endtask

    task automatic run_until(input int last);
        exp_t e;
        while (edge_n < last) step();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, edge %0d never reached, expected %08h", e.tag, e.at, e.val);
        end
    endtask

    task automatic load_prog(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] i3);
        for (int i = 0; i < 16; i++) dut.rom.storage[i] = 32'd0;
        dut.rom.storage[0] = i0;
        dut.rom.storage[1] = i1;
        dut.rom.storage[2] = i2;
        dut.rom.storage[3] = i3;
    endtask

    task automatic reset_and_load(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] i3);
        reset = 1'b1;
        step();
        step();
        load_prog(i0, i1, i2, i3);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        edge_n = 0;
    endtask

    function automatic logic [31:0] regs_or();
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) acc = acc | dut.cpu.register.storage[i];
        return acc;
    endfunction

    task automatic push_mul_expect(input string pfx);
        expect_at(5, 2, 32'h0000_0003, {pfx, "_r2"});
        expect_at(6, 3, 32'h0000_0005, {pfx, "_r3_during_stall"});
        expect_at(R1 - 1, 1, 32'h0000_0000, {pfx, "_r1_early"});
        expect_at(R1, 1, 32'h0000_000F, {pfx, "_r1"});
        expect_at(R4 - 1, 4, 32'h0000_0000, {pfx, "_r4_early"});
        expect_at(R4, 4, 32'h0000_0001, {pfx, "_r4"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nop;
        nop = 32'd0;

        add_vec("ori",        ri(ORI,1,0,16'h1234), nop, nop, nop, 1, 32'h0000_1234);
        add_vec("lui_addiu",  ri(LUI,1,0,16'h8000), ri(ADDIU,1,1,16'hFFFF), nop, nop, 1, 32'h7FFF_FFFF);
        add_vec("subu",       ri(LUI,1,0,16'h8000), ri(ADDIU,1,1,16'hFFFF), rr(6'h23,5,0,1), nop, 5, 32'h8000_0001);
        add_vec("sra_pos",    ri(LUI,1,0,16'h8000), ri(ADDIU,1,1,16'hFFFF), sh(6'h03,6,1,5'd4), nop, 6, 32'h07FF_FFFF);
        add_vec("mul",        ri(ORI,2,0,16'h0003), ri(ORI,3,0,16'h0005), mul(1,2,3), nop, 1, 32'h0000_000F);
        add_vec("andi",       ri(ORI,1,0,16'hF0F0), ri(ANDI,2,1,16'hFF00), nop, nop, 2, 32'h0000_F000);
        add_vec("xori",       ri(ORI,1,0,16'hF0F0), ri(XORI,2,1,16'hFFFF), nop, nop, 2, 32'h0000_0F0F);
        add_vec("nor",        ri(ORI,1,0,16'h0001), rr(6'h27,2,1,0), nop, nop, 2, 32'hFFFF_FFFE);
        add_vec("slt_signed", ri(ADDIU,1,0,16'hFFFF), rr(6'h2A,2,1,0), nop, nop, 2, 32'h0000_0001);
        add_vec("sltu",       ri(ADDIU,1,0,16'hFFFF), rr(6'h2B,3,0,1), nop, nop, 3, 32'h0000_0001);
        add_vec("sll_srl",    ri(ORI,1,0,16'h8001), sh(6'h00,2,1,5'd16), sh(6'h02,3,2,5'd31), nop, 3, 32'h0000_0001);
        add_vec("sll_val",    ri(ORI,1,0,16'h8001), sh(6'h00,2,1,5'd16), nop, nop, 2, 32'h8001_0000);
        add_vec("sra_neg",    ri(LUI,1,0,16'h8000), sh(6'h03,2,1,5'd31), nop, nop, 2, 32'hFFFF_FFFF);
        add_vec("r0_discard", ri(ORI,0,0,16'h0005), ri(ORI,1,0,16'h0007), rr(6'h21,2,0,1), nop, 2, 32'h0000_0007);
        add_vec("r0_zero",    ri(ORI,0,0,16'h0005), nop, nop, nop, 0, 32'h0000_0000);
        add_vec("bad_op_nop", ri(ORI,1,0,16'h0003), 32'hFC21_FFFF, rr(6'h21,2,1,1), nop, 2, 32'h0000_0006);
        add_vec("add_wrap",   ri(LUI,1,0,16'hFFFF), ri(ORI,1,1,16'hFFFF), ri(ADDIU,2,1,16'h0002), nop, 2, 32'h0000_0001);
        add_vec("mul_low",    ri(LUI,1,0,16'h1234), ri(ORI,2,0,16'h0010), mul(3,1,2), nop, 3, 32'h2340_0000);
        add_vec("mul_dep",    ri(ORI,2,0,16'h0003), ri(ORI,3,0,16'h0005), mul(1,2,3), rr(6'h21,4,1,1), 4, 32'h0000_001E);
        add_vec("or_r",       ri(ORI,1,0,16'h00F0), ri(ORI,2,0,16'h0F00), rr(6'h25,3,1,2), nop, 3, 32'h0000_0FF0);
        add_vec("xor_r",      ri(ORI,1,0,16'hFF00), ri(ORI,2,0,16'h0FF0), rr(6'h26,3,1,2), nop, 3, 32'h0000_F0F0);
        add_vec("and_r",      ri(ORI,1,0,16'hFF00), ri(ORI,2,0,16'h0FF0), rr(6'h24,3,1,2), nop, 3, 32'h0000_0F00);

        // Long reset with a program already in ROM: nothing may execute
        load_prog(ri(ORI,1,0,16'h1234), nop, nop, nop);
        for (int i = 0; i < 10; i++) step();
        check("reset_pc", dut.cpu.pc_q, 32'd0);
        check("reset_regs", regs_or(), 32'd0);
        check("reset_rom_out", dut.rom.data, 32'd0);

        // First-result latency
        release_reset();
        expect_at(4, 1, 32'h0000_0000, "ori_latency_e4");
        expect_at(5, 1, 32'h0000_1234, "ori_latency_e5");
        run_until(8);

        // Back-to-back writes to the same register, including a dependent AND
        reset_and_load(ri(ORI,1,0,16'h1234), rr(6'h24,1,1,0), ri(ORI,1,0,16'h1234), ri(ORI,1,0,16'h89AB));
        release_reset();
        expect_at(5,  1, 32'h0000_1234, "seq_w0");
        expect_at(W1, 1, 32'h0000_0000, "seq_w1");
        expect_at(W2, 1, 32'h0000_1234, "seq_w2");
        expect_at(W3, 1, 32'h0000_89AB, "seq_w3");
        run_until(W3 + 3);

        // MUL occupancy delays the following instruction
        reset_and_load(ri(ORI,2,0,16'h0003), ri(ORI,3,0,16'h0005), mul(1,2,3), ri(ORI,4,0,16'h0001));
        release_reset();
        push_mul_expect("mul_stall");
        run_until(R4 + 3);

        // Reset asserted mid-stall, then the same program must replay with full timing
        reset_and_load(ri(ORI,2,0,16'h0003), ri(ORI,3,0,16'h0005), mul(1,2,3), ri(ORI,4,0,16'h0001));
        release_reset();
        run_until(MID);
        reset = 1'b1;
        step();
        check("midstall_reset_regs", regs_or(), 32'd0);
        release_reset();
        push_mul_expect("after_mid_reset");
        run_until(R4 + 3);

        // Table-driven ALU vectors, checked once the program has drained
        foreach (vecs[k]) begin
            reset_and_load(vecs[k].i0, vecs[k].i1, vecs[k].i2, vecs[k].i3);
            release_reset();
            expect_at(25, vecs[k].r, vecs[k].val, vecs[k].tag);
            run_until(25);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
